alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes a request into ALU operands and operation select.
// Build option ALU_ISSUE_SKID_EN selects a 2-entry skid buffer; otherwise a single output register.
module alu_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               opcode,
    input  logic [2:0]               funct3,
    input  logic [6:0]               funct7,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic                     is_branch
);

    // Entry layout: {illegal, is_branch, Operation, SrcA, SrcB}
    localparam int EW = 2 * DATA_WIDTH + OPCODE_LENGTH + 2;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_BEQ = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_BGE = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_BNE = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

    logic [DATA_WIDTH-1:0]    dec_a;
    logic [DATA_WIDTH-1:0]    dec_b;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;
    logic                     dec_br;
    logic [EW-1:0]            dec_entry;

    always_comb begin
        dec_a   = rs1_data;
        dec_b   = '0;
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        dec_br  = 1'b0;
        case (opcode)
            OPC_RTYPE, OPC_ITYPE: begin
                dec_b = (opcode == OPC_RTYPE) ? rs2_data : imm;
                case (funct3)
                    3'b000: dec_op = (opcode == OPC_RTYPE && funct7[5]) ? OP_SUB : OP_ADD;
                    3'b001: dec_op = OP_SLL;
                    3'b010: dec_op = OP_SLT;
                    3'b011: dec_ill = 1'b1;
                    3'b100: dec_op = OP_XOR;
                    3'b101: dec_op = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110: dec_op = OP_OR;
                    default: dec_op = OP_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE: begin
                dec_b  = imm;
                dec_op = OP_ADD;
            end
            OPC_BRANCH: begin
                dec_b  = rs2_data;
                dec_br = 1'b1;
                case (funct3)
                    3'b000:  dec_op = OP_BEQ;
                    3'b001:  dec_op = OP_BNE;
                    3'b100:  dec_op = OP_SLT;
                    3'b101:  dec_op = OP_BGE;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Undecodable requests still travel through the pipe, but carry no operands.
        if (dec_ill) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = OP_ILL;
            dec_br = 1'b0;
        end
        dec_entry = {dec_ill, dec_br, dec_op, dec_a, dec_b};
    end

    // Handshake: a word moves upstream on in_valid && in_ready and downstream on
    // out_valid && out_ready at the rising edge; a held output never changes while stalled.
    logic          accept;
    logic          drain;
    logic [1:0]    count_q, count_d;
    logic [EW-1:0] head_q, head_d;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
    logic [EW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) begin
                        head_d  = dec_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && drain) begin
                        head_d = dec_entry;
                    end else if (accept) begin
                        skid_d  = dec_entry;
                        count_d = 2'd2;
                    end else if (drain) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a drain can happen.
                    if (drain) begin
                        head_d  = skid_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
`else
    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (accept) begin
            head_d  = dec_entry;
            count_d = 2'd1;
        end else if (drain) begin
            count_d = 2'd0;
        end
    end

    assign in_ready = !out_valid || out_ready;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign {illegal, is_branch, Operation, SrcA, SrcB} = head_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: scoreboard of decoded entries plus handshake, flush and reset steps.
module tb_alu_issue;

    localparam int DW = 32;
    localparam int OL = 4;
    localparam int EW = 2 * DW + OL + 2;

`ifdef ALU_ISSUE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] imm;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [OL-1:0] Operation;
    logic          illegal;
    logic          is_branch;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    alu_issue #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .illegal   (illegal),
        .is_branch (is_branch)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference decode ----------------
    function automatic logic [EW-1:0] model(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b, input logic [DW-1:0] im);
        logic [3:0]    o;
        logic [DW-1:0] sb;
        logic          bad;
        logic          br;
        o = 4'h0; sb = '0; bad = 1'b0; br = 1'b0;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            sb = (op == 7'b0110011) ? b : im;
            case (f3)
                3'd0: o = (op == 7'b0110011 && f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
                3'd1: o = 4'b0100;
                3'd2: o = 4'b1100;
                3'd3: bad = 1'b1;
                3'd4: o = 4'b0011;
                3'd5: o = f7[5] ? 4'b0111 : 4'b0101;
                3'd6: o = 4'b0001;
                3'd7: o = 4'b0000;
            endcase
        end else if (op == 7'b0000011 || op == 7'b0100011) begin
            sb = im;
            o  = 4'b0010;
        end else if (op == 7'b1100011) begin
            sb = b;
            br = 1'b1;
            if (f3 == 3'd0) o = 4'b1000;
            else if (f3 == 3'd1) o = 4'b1101;
            else if (f3 == 3'd4) o = 4'b1100;
            else if (f3 == 3'd5) o = 4'b1001;
            else bad = 1'b1;
        end else begin
            bad = 1'b1;
        end
        if (bad) return {1'b1, 1'b0, 4'b1111, {DW{1'b0}}, {DW{1'b0}}};
        return {1'b0, br, o, a, sb};
    endfunction

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge reset_n) exp_q.delete();

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("out_valid_vs_sb", EW'(out_valid), EW'(exp_q.size() != 0));
            if (out_valid === 1'b1 && exp_q.size() != 0) begin
                check("out_fields", {illegal, is_branch, Operation, SrcA, SrcB}, exp_q[0]);
                if (out_ready && !flush) void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back(model(opcode, funct3, funct7, rs1_data, rs2_data, imm));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rand_payload();
        case ($urandom_range(0, 5))
            0: opcode = 7'b0110011;
            1: opcode = 7'b0010011;
            2: opcode = 7'b0000011;
            3: opcode = 7'b0100011;
            4: opcode = 7'b1100011;
            default: opcode = 7'b1111111;
        endcase
        funct3   = 3'($urandom_range(0, 7));
        funct7   = $urandom_range(0, 1) ? 7'b0100000 : 7'b0000000;
        rs1_data = $urandom;
        rs2_data = $urandom;
        imm      = $urandom;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] im);
        int waited;
        opcode = op; funct3 = f3; funct7 = f7;
        rs1_data = a; rs2_data = b; imm = im;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("send_accept", EW'(in_ready), EW'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic stream(input int cycles, input logic rdy, output int acc);
        logic got;
        out_ready = rdy;
        in_valid  = 1'b1;
        rand_payload();
        acc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            got = in_ready;
            if (got) acc++;
            @(posedge clk); #1;
            if (got) rand_payload();
        end
    endtask

    task automatic drain_all();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_out_valid", EW'(out_valid), EW'(1'b0));
        check("drain_sb_empty", EW'(exp_q.size()), EW'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        reset_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        #1 reset_n = 1'b0;
        #2;
        check("rst_out_valid", EW'(out_valid), EW'(1'b0));
        check("rst_in_ready", EW'(in_ready), EW'(1'b1));
        check("rst_fields", {illegal, is_branch, Operation, SrcA, SrcB}, '0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        check("post_rst_in_ready", EW'(in_ready), EW'(1'b1));

        // SUB with one-cycle latency
        send(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0);
        check("sub_valid", EW'(out_valid), EW'(1'b1));
        check("sub_op", EW'(Operation), EW'(4'b0110));
        check("sub_srca", EW'(SrcA), EW'(32'd10));
        check("sub_srcb", EW'(SrcB), EW'(32'd3));

        send(7'b0010011, 3'b101, 7'b0100000, 32'd77, 32'd5, 32'd4);
        check("srai_op", EW'(Operation), EW'(4'b0111));
        check("srai_srcb", EW'(SrcB), EW'(32'd4));
        send(7'b0010011, 3'b000, 7'b0100000, 32'd77, 32'd5, 32'd4);
        check("addi_op", EW'(Operation), EW'(4'b0010));

        send(7'b1100011, 3'b001, 7'b0000000, 32'd1, 32'd2, 32'd0);
        check("bne_op", EW'(Operation), EW'(4'b1101));
        check("bne_branch", EW'(is_branch), EW'(1'b1));
        send(7'b1100011, 3'b010, 7'b0000000, 32'd1, 32'd2, 32'd0);
        check("br_ill", EW'(illegal), EW'(1'b1));
        check("br_ill_op", EW'(Operation), EW'(4'b1111));
        check("br_ill_srca", EW'(SrcA), EW'(32'd0));

        // Sweep of every funct3 across the decodable opcode classes
        for (int f = 0; f < 8; f++) begin
            send(7'b0110011, 3'(f), (f % 2 == 0) ? 7'b0100000 : 7'b0000000, $urandom, $urandom, $urandom);
            send(7'b0010011, 3'(f), 7'b0100000, $urandom, $urandom, $urandom);
            send(7'b1100011, 3'(f), 7'b0000000, $urandom, $urandom, $urandom);
        end
        send(7'b0000011, 3'b010, 7'b0000000, $urandom, $urandom, $urandom);
        send(7'b0100011, 3'b010, 7'b0000000, $urandom, $urandom, $urandom);
        send(7'b0110111, 3'b000, 7'b0000000, $urandom, $urandom, $urandom);
        drain_all();

        // Backpressure: capacity then stall
        stream(5, 1'b0, acc);
        check("stall_accepted", EW'(acc), EW'(DEPTH));
        check("stall_in_ready", EW'(in_ready), EW'(1'b0));
        drain_all();

        // Sustained one transfer per cycle
        stream(8, 1'b1, acc);
        check("stream_accepted", EW'(acc), EW'(8));
        drain_all();

        // Flush with new request presented and held entries
        stream(3, 1'b0, acc);
        check("flush_pre_valid", EW'(out_valid), EW'(1'b1));
        flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; rand_payload();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", EW'(out_valid), EW'(1'b0));
        check("flush_in_ready", EW'(in_ready), EW'(1'b1));
        @(posedge clk); #1;
        check("flush_no_emit", EW'(out_valid), EW'(1'b0));

        // Asynchronous reset mid-stream
        stream(2, 1'b0, acc);
        check("rst_pre_valid", EW'(out_valid), EW'(1'b1));
        #2 reset_n = 1'b0;
        #1;
        check("arst_out_valid", EW'(out_valid), EW'(1'b0));
        check("arst_in_ready", EW'(in_ready), EW'(1'b1));
        check("arst_op", EW'(Operation), EW'(4'b0000));
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("arst_held", EW'(out_valid), EW'(1'b0));
        reset_n = 1'b1;
        send(7'b0110011, 3'b111, 7'b0000000, 32'hF0F0_0000, 32'h0FF0_0000, 32'd0);
        check("post_arst_op", EW'(Operation), EW'(4'b0000));
        check("post_arst_valid", EW'(out_valid), EW'(1'b1));
        drain_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
